// File: rtl/gp2_share_grant_sched.sv
// Shared-group-2 grant scheduler: latches one request flag vector, sorts each flagged requestor
// onto column bank 0 or 1 by mode set, then grants at most one requestor per bank per cycle.
module gp2_share_grant_sched #(
  parameter int SHARED_BANK_NUM    = 5,
  parameter int RQST_ADDR_BITWIDTH = 2,
  parameter int MODE_BITWIDTH      = 3,
  parameter int IDX_BITWIDTH       = 3
) (
  input  logic                                          sys_clk,
  input  logic                                          rstn,
  input  logic                                          rqst_valid_i,
  output logic                                          rqst_ready_o,
  input  logic [SHARED_BANK_NUM-1:0]                    share_rqstFlag_i,
  input  logic [RQST_ADDR_BITWIDTH*SHARED_BANK_NUM-1:0] rqst_addr_i,
  input  logic [MODE_BITWIDTH-1:0]                      modeSet_i,
  output logic                                          bank0_en_o,
  output logic [IDX_BITWIDTH-1:0]                       bank0_idx_o,
  output logic                                          bank1_en_o,
  output logic [IDX_BITWIDTH-1:0]                       bank1_idx_o,
  output logic [SHARED_BANK_NUM-1:0]                    grant_o,
  output logic                                          serve_done_o,
  output logic [1:0]                                    dbg_state_o
);

  // Handshake: a vector is consumed on a rising edge where rqst_valid_i & rqst_ready_o;
  // ready is high only in IDLE, and valid is ignored (vector not consumed) in any other state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [SHARED_BANK_NUM-1:0]     r_pend0;
  logic [SHARED_BANK_NUM-1:0]     r_pend1;
  logic [SHARED_BANK_NUM-1:0]     w_pend0_nxt;
  logic [SHARED_BANK_NUM-1:0]     w_pend1_nxt;
  logic [SHARED_BANK_NUM-1:0]     w_map0;
  logic [SHARED_BANK_NUM-1:0]     w_map1;
  logic [SHARED_BANK_NUM-1:0]     w_gnt0;
  logic [SHARED_BANK_NUM-1:0]     w_gnt1;
  logic [SHARED_BANK_NUM-1:0]     w_rem0;
  logic [SHARED_BANK_NUM-1:0]     w_rem1;
  logic [IDX_BITWIDTH-1:0]        w_idx0;
  logic [IDX_BITWIDTH-1:0]        w_idx1;
  logic [RQST_ADDR_BITWIDTH-1:0]  w_addr;
  logic                           w_accept;
  logic                           w_serve;

  // Bank sort of the incoming vector; unmapped (mode, addr) pairs are dropped here.
  always_comb begin
    w_map0 = '0;
    w_map1 = '0;
    w_addr = '0;
    for (int i = 0; i < SHARED_BANK_NUM; i++) begin
      w_addr = rqst_addr_i[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH];
      if (share_rqstFlag_i[i]) begin
        case (modeSet_i)
          MODE_BITWIDTH'(0), MODE_BITWIDTH'(1): begin
            w_map0[i] = ~w_addr[0];
            w_map1[i] = w_addr[0];
          end
          MODE_BITWIDTH'(2), MODE_BITWIDTH'(3): begin
            w_map0[i] = ~w_addr[1];
            w_map1[i] = w_addr[1];
          end
          MODE_BITWIDTH'(4): begin
            w_map0[i] = (w_addr[1:0] == 2'b01);
            w_map1[i] = (w_addr[1:0] == 2'b10);
          end
          MODE_BITWIDTH'(5): begin
            w_map0[i] = (w_addr[1:0] == 2'b00);
            w_map1[i] = (w_addr[1:0] == 2'b11);
          end
          default: begin
            w_map0[i] = 1'b0;
            w_map1[i] = 1'b0;
          end
        endcase
      end
    end
  end

  // Lowest pending index wins each bank; scanning downward leaves the lowest hit last.
  always_comb begin
    w_gnt0 = '0;
    w_gnt1 = '0;
    w_idx0 = '0;
    w_idx1 = '0;
    for (int i = SHARED_BANK_NUM - 1; i >= 0; i--) begin
      if (r_pend0[i]) begin
        w_idx0    = IDX_BITWIDTH'(i);
        w_gnt0    = '0;
        w_gnt0[i] = 1'b1;
      end
      if (r_pend1[i]) begin
        w_idx1    = IDX_BITWIDTH'(i);
        w_gnt1    = '0;
        w_gnt1[i] = 1'b1;
      end
    end
  end

  assign w_rem0   = r_pend0 & ~w_gnt0;
  assign w_rem1   = r_pend1 & ~w_gnt1;
  assign w_accept = rqst_valid_i && (r_state == ST_IDLE);
  assign w_serve  = (r_state == ST_SERVE);

  always_comb begin
    w_state_nxt = r_state;
    w_pend0_nxt = r_pend0;
    w_pend1_nxt = r_pend1;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_pend0_nxt = w_map0;
          w_pend1_nxt = w_map1;
          w_state_nxt = (|(w_map0 | w_map1)) ? ST_SERVE : ST_DONE;
        end
      end
      ST_SERVE: begin
        w_pend0_nxt = w_rem0;
        w_pend1_nxt = w_rem1;
        if (!(|(w_rem0 | w_rem1))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pend0_nxt = '0;
        w_pend1_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_pend0 <= '0;
      r_pend1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend0 <= w_pend0_nxt;
      r_pend1 <= w_pend1_nxt;
    end
  end

  assign rqst_ready_o = (r_state == ST_IDLE);
  assign bank0_en_o   = w_serve && (|r_pend0);
  assign bank1_en_o   = w_serve && (|r_pend1);
  assign bank0_idx_o  = bank0_en_o ? w_idx0 : '0;
  assign bank1_idx_o  = bank1_en_o ? w_idx1 : '0;
  assign grant_o      = w_serve ? (w_gnt0 | w_gnt1) : '0;
  assign serve_done_o = (r_state == ST_DONE);
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_gp2_share_grant_sched.sv
// Bench for gp2_share_grant_sched: directed scenarios plus random vectors scored against a
// queue-based per-bank model of the grant schedule.
module tb_gp2_share_grant_sched;

  logic        sys_clk;
  logic        rstn;
  logic        rqst_valid_i;
  logic        rqst_ready_o;
  logic [4:0]  share_rqstFlag_i;
  logic [9:0]  rqst_addr_i;
  logic [2:0]  modeSet_i;
  logic        bank0_en_o;
  logic [2:0]  bank0_idx_o;
  logic        bank1_en_o;
  logic [2:0]  bank1_idx_o;
  logic [4:0]  grant_o;
  logic        serve_done_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  gp2_share_grant_sched dut (
    .sys_clk          (sys_clk),
    .rstn             (rstn),
    .rqst_valid_i     (rqst_valid_i),
    .rqst_ready_o     (rqst_ready_o),
    .share_rqstFlag_i (share_rqstFlag_i),
    .rqst_addr_i      (rqst_addr_i),
    .modeSet_i        (modeSet_i),
    .bank0_en_o       (bank0_en_o),
    .bank0_idx_o      (bank0_idx_o),
    .bank1_en_o       (bank1_en_o),
    .bank1_idx_o      (bank1_idx_o),
    .grant_o          (grant_o),
    .serve_done_o     (serve_done_o),
    .dbg_state_o      (dbg_state_o)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Observed outputs packed as {en0, idx0, en1, idx1, grant, done, ready}.
  function automatic logic [14:0] obs();
    return {bank0_en_o, bank0_idx_o, bank1_en_o, bank1_idx_o, grant_o, serve_done_o, rqst_ready_o};
  endfunction

  localparam logic [14:0] IDLE_VEC = 15'b0_000_0_000_00000_0_1;

  task automatic test_reset();
    rstn = 1'b0;
    rqst_valid_i = 1'b0;
    share_rqstFlag_i = '0;
    rqst_addr_i = '0;
    modeSet_i = '0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (obs() !== IDLE_VEC) begin
      errors++;
      $display("FAIL reset_asserted got %h exp %h", obs(), IDLE_VEC);
    end
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      checks++;
      if (obs() !== IDLE_VEC) begin
        errors++;
        $display("FAIL reset_idle_hold c%0d got %h exp %h", k, obs(), IDLE_VEC);
      end
    end
  endtask

  // One job: the model lists bank members in index order; cycle k grants the k-th of each list.
  task automatic run_job(input logic [4:0] f, input logic [9:0] a, input logic [2:0] m,
                         input bit hold, input string name);
    int q0[$];
    int q1[$];
    int n;
    logic [1:0] aa;
    logic [14:0] exp_v;
    logic e0, e1;
    logic [2:0] i0, i1;
    logic [4:0] g;
    for (int i = 0; i < 5; i++) begin
      aa = a[i*2 +: 2];
      if (f[i]) begin
        if (m <= 3'd1) begin
          if (aa[0]) q1.push_back(i); else q0.push_back(i);
        end else if (m <= 3'd3) begin
          if (aa[1]) q1.push_back(i); else q0.push_back(i);
        end else if (m == 3'd4) begin
          if (aa == 2'd1) q0.push_back(i);
          if (aa == 2'd2) q1.push_back(i);
        end else if (m == 3'd5) begin
          if (aa == 2'd0) q0.push_back(i);
          if (aa == 2'd3) q1.push_back(i);
        end
      end
    end
    n = (q0.size() > q1.size()) ? q0.size() : q1.size();

    @(negedge sys_clk);
    checks++;
    if (rqst_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept got %b exp 1", name, rqst_ready_o);
    end
    rqst_valid_i = 1'b1;
    share_rqstFlag_i = f;
    rqst_addr_i = a;
    modeSet_i = m;

    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      if (hold) begin
        share_rqstFlag_i = 5'($urandom);
        rqst_addr_i = 10'($urandom);
        modeSet_i = 3'($urandom);
      end else begin
        rqst_valid_i = 1'b0;
      end
      e0 = 1'b0; i0 = '0; e1 = 1'b0; i1 = '0; g = '0;
      if (k < q0.size()) begin
        e0 = 1'b1; i0 = 3'(q0[k]); g[q0[k]] = 1'b1;
      end
      if (k < q1.size()) begin
        e1 = 1'b1; i1 = 3'(q1[k]); g[q1[k]] = 1'b1;
      end
      exp_v = {e0, i0, e1, i1, g, 1'b0, 1'b0};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL %s serve_c%0d got %h exp %h", name, k + 1, obs(), exp_v);
      end
    end

    @(negedge sys_clk);
    if (hold) share_rqstFlag_i = 5'($urandom);
    else rqst_valid_i = 1'b0;
    exp_v = 15'b0_000_0_000_00000_1_0;
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("FAIL %s done_cycle got %h exp %h", name, obs(), exp_v);
    end

    @(negedge sys_clk);
    rqst_valid_i = 1'b0;
    checks++;
    if (obs() !== IDLE_VEC) begin
      errors++;
      $display("FAIL %s back_to_idle got %h exp %h", name, obs(), IDLE_VEC);
    end
  endtask

  task automatic test_mode_split();
    run_job(5'b11111, {2'd1, 2'd0, 2'd1, 2'd0, 2'd0}, 3'b000, 1'b0, "mode000_all");
    run_job(5'b00111, {2'd0, 2'd0, 2'd3, 2'd2, 2'd1}, 3'b100, 1'b0, "mode100_drop");
    run_job(5'b11111, {2'd3, 2'd0, 2'd1, 2'd2, 2'd0}, 3'b101, 1'b0, "mode101");
    run_job(5'b10110, {2'd2, 2'd1, 2'd3, 2'd0, 2'd2}, 3'b011, 1'b0, "mode011");
  endtask

  task automatic test_empty();
    run_job(5'b00000, 10'h3a5, 3'b000, 1'b0, "no_flags");
    run_job(5'b11111, 10'h1e4, 3'b110, 1'b0, "mode110");
    run_job(5'b11111, 10'h2b7, 3'b111, 1'b0, "mode111");
  endtask

  task automatic test_reset_mid_serve();
    logic [14:0] exp_v;
    @(negedge sys_clk);
    rqst_valid_i = 1'b1;
    share_rqstFlag_i = 5'b11111;
    rqst_addr_i = {2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
    modeSet_i = 3'b000;
    @(negedge sys_clk);
    rqst_valid_i = 1'b0;
    exp_v = {1'b1, 3'd0, 1'b1, 3'd2, 5'b00101, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_first_grant got %h exp %h", obs(), exp_v);
    end
    rstn = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (obs() !== IDLE_VEC) begin
      errors++;
      $display("FAIL mid_reset_in_reset got %h exp %h", obs(), IDLE_VEC);
    end
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      checks++;
      if (obs() !== IDLE_VEC) begin
        errors++;
        $display("FAIL mid_reset_after c%0d got %h exp %h", k, obs(), IDLE_VEC);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_job(5'b11011, {2'd0, 2'd2, 2'd1, 2'd2, 2'd0}, 3'b010, 1'b1, "hold_valid_a");
    run_job(5'b01101, {2'd3, 2'd3, 2'd0, 2'd1, 2'd3}, 3'b001, 1'b1, "hold_valid_b");
  endtask

  task automatic test_random();
    logic [2:0] m;
    for (int t = 0; t < 40; t++) begin
      m = 3'($urandom_range(0, 7));
      run_job(5'($urandom), 10'($urandom), m, 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_mode_split();
    test_empty();
    test_reset_mid_serve();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
